bus_txn_arbiter: RTL

- Round-robin arbiter and sequencer that shares the single bus-transaction slave FSM (req/rw in; busy/done/data_valid out) between NUM_REQ masters.
- Grants one master at a time and issues a one-cycle slv_req to the slave, holding slv_rw stable for the whole transaction.
- Routes done/data_valid back to the granted master; a watchdog flags slave hangs.
- Sits between master logic and the slave FSM in the same tile.

---
 rtl/bus_txn_arb_pkg.sv | 20 ++
 rtl/bus_txn_arbiter_rr_picker.sv | 40 ++++
 rtl/bus_txn_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bus_txn_arb_pkg.sv
// Shared types and sizing helpers for the bus transaction arbiter and its
// round-robin picker.
package bus_txn_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } arb_state_e;

    // Wide enough for the largest supported TIMEOUT (255).
    localparam int TMO_CNT_W = 8;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_txn_arbiter_rr_picker.sv
// Combinational round-robin picker: the first requester at or above rr_ptr
// wins, scanning upward and wrapping modulo NUM_REQ.
module rr_picker
    import bus_txn_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any_req
);

    logic [IDX_W:0]   cand_sum [NUM_REQ];
    logic [IDX_W-1:0] cand_idx [NUM_REQ];

    // cand_idx[k] is the master index examined at scan offset k from rr_ptr.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand_sum[gi] = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
        assign cand_idx[gi] = (cand_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                            ? IDX_W'(cand_sum[gi] - (IDX_W+1)'(NUM_REQ))
                            : cand_sum[gi][IDX_W-1:0];
    end

    always_comb begin
        winner_idx = '0;
        any_req    = 1'b0;
        // Scanning from the far end lets the closest offset overwrite last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[cand_idx[i]]) begin
                winner_idx = cand_idx[i];
                any_req    = 1'b1;
            end
        end
        winner = any_req ? (NUM_REQ'(1) << winner_idx) : '0;
    end

endmodule

// File: rtl/bus_txn_arbiter.sv
// Round-robin arbiter that shares one bus-transaction slave between NUM_REQ
// masters, routing completion/timeout pulses back to the granted master.
module bus_txn_arbiter
    import bus_txn_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rw,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] data_valid,
    output logic [NUM_REQ-1:0] err,
    output logic               arb_busy,
    output logic               slv_req,
    output logic               slv_rw,
    input  logic               slv_busy,
    input  logic               slv_done,
    input  logic               slv_data_valid
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);
    localparam logic [TMO_CNT_W-1:0] TMO_MAX  = TMO_CNT_W'(TIMEOUT);

    arb_state_e             state_reg, state_next;
    logic [NUM_REQ-1:0]     grant_reg, done_reg, dv_reg, err_reg;
    logic [NUM_REQ-1:0]     pick_onehot;
    logic [IDX_W-1:0]       rr_ptr_reg, gidx_reg, pick_idx, rr_ptr_next;
    logic [TMO_CNT_W-1:0]   tmo_cnt_reg;
    logic                   pick_any, tmo_hit;
    logic                   arb_busy_reg, slv_req_reg, slv_rw_reg;
    logic                   unused_slv_busy;

    // Slave busy is informational only; sequencing relies on slv_done.
    assign unused_slv_busy = slv_busy;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req),
        .rr_ptr     (rr_ptr_reg),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any_req    (pick_any)
    );

    // Exiting on the edge where the counter would reach TIMEOUT gives
    // exactly TIMEOUT cycles in WAIT.
    assign tmo_hit     = (tmo_cnt_reg >= TMO_LAST);
    assign rr_ptr_next = (gidx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_reg + IDX_W'(1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (pick_any) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (slv_done)     state_next = ST_DONE;
                else if (tmo_hit) state_next = ST_ERR;
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_ERR:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= '0;
            done_reg     <= '0;
            dv_reg       <= '0;
            err_reg      <= '0;
            arb_busy_reg <= 1'b0;
            slv_req_reg  <= 1'b0;
            slv_rw_reg   <= 1'b0;
            rr_ptr_reg   <= '0;
            gidx_reg     <= '0;
            tmo_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            arb_busy_reg <= (state_next != ST_IDLE);
            slv_req_reg  <= 1'b0;
            done_reg     <= '0;
            dv_reg       <= '0;
            err_reg      <= '0;

            if (state_reg == ST_WAIT && tmo_cnt_reg != TMO_MAX)
                tmo_cnt_reg <= tmo_cnt_reg + TMO_CNT_W'(1);

            case (state_next)
                ST_ISSUE: begin
                    if (state_reg == ST_IDLE) begin
                        grant_reg   <= pick_onehot;
                        gidx_reg    <= pick_idx;
                        slv_rw_reg  <= |(rw & pick_onehot);
                        slv_req_reg <= 1'b1;
                        tmo_cnt_reg <= '0;
                    end
                end
                ST_DONE: begin
                    done_reg   <= grant_reg;
                    dv_reg     <= slv_data_valid ? grant_reg : '0;
                    rr_ptr_reg <= rr_ptr_next;
                end
                ST_ERR: begin
                    err_reg    <= grant_reg;
                    rr_ptr_reg <= rr_ptr_next;
                end
                ST_IDLE: begin
                    grant_reg  <= '0;
                    slv_rw_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign grant      = grant_reg;
    assign done       = done_reg;
    assign data_valid = dv_reg;
    assign err        = err_reg;
    assign arb_busy   = arb_busy_reg;
    assign slv_req    = slv_req_reg;
    assign slv_rw     = slv_rw_reg;

endmodule
